// File: rtl/mat_mac_seq_if.sv
// mat_mac_seq_if: bus bundle between the matrix-multiply sequencer and its
// surroundings (top-level control, operand memories, MAC chain, C memory).
//   master : sequencer side (drives busy/done, reads, MAC control, C writes)
//   slave  : environment side (drives start/abort and accumulator results)
// Parameters: AW = log2(N) (element address is 2*AW bits), DW = data width.
interface mat_mac_seq_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [2*AW-1:0] a_addr;
    logic [2*AW-1:0] b_addr;
    logic            mac_en;
    logic            mac_clr;
    logic            mac_last;
    logic            acc_valid;
    logic [DW-1:0]   acc_data;
    logic            c_we;
    logic [2*AW-1:0] c_addr;
    logic [DW-1:0]   c_data;

    modport master (
        input  start, abort, acc_valid, acc_data,
        output busy, done, rd_en, a_addr, b_addr,
        output mac_en, mac_clr, mac_last, c_we, c_addr, c_data
    );

    modport slave (
        output start, abort, acc_valid, acc_data,
        input  busy, done, rd_en, a_addr, b_addr,
        input  mac_en, mac_clr, mac_last, c_we, c_addr, c_data
    );
endinterface

// File: rtl/mat_mac_seq.sv
// mat_mac_seq: sequencer for the NxN fixed-point matrix multiply C = A x B.
// Issues A/B operand reads in i/j/k order (k innermost), drives the MAC
// enable/clear/last-term controls through a MEM_LAT-deep delay line, and
// writes the in-order accumulator results to C memory in row-major order.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : mat_mac_seq_if.master (start/abort/busy/done, rd_en, a_addr,
//               b_addr, mac_en, mac_clr, mac_last, acc_valid, acc_data,
//               c_we, c_addr, c_data)
// Optional (macro MAT_MAC_SEQ_PERF_EN):
//   cyc_cnt   : RUN+DRAIN cycle count of the latest multiply (saturating)
//   stall_err : sticky flag, DRAIN lasted more than 64 cycles
module mat_mac_seq #(
    parameter int N       = 32,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    mat_mac_seq_if.master  bus
`ifdef MAT_MAC_SEQ_PERF_EN
    ,
    output logic [31:0]    cyc_cnt,
    output logic           stall_err
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int            WW     = 2*AW + 1;
    localparam logic [WW-1:0] W_FULL = WW'(N*N);
    localparam logic [AW-1:0] KMAX   = AW'(N-1);

    state_t                state_q, state_d;
    logic [AW-1:0]         i_q, j_q, k_q, i_d, j_d, k_d;
    logic                  rd_en_q;
    logic [2*AW-1:0]       a_addr_q, b_addr_q;
    logic [MEM_LAT-1:0]    en_pipe_q, last_pipe_q;
    logic                  clr_q;
    logic [WW-1:0]         w_q;
    logic                  c_we_q;
    logic [2*AW-1:0]       c_addr_q;
    logic [DW-1:0]         c_data_q;

    logic active, accept, abort_hit, issue_last, wr_ok;

    assign active     = (state_q == RUN) || (state_q == DRAIN);
    assign accept     = (state_q == IDLE) && bus.start;
    assign abort_hit  = active && bus.abort;
    assign issue_last = rd_en_q && (i_q == KMAX) && (j_q == KMAX) && (k_q == KMAX);
    // Results past N*N cannot legally arrive; the counter simply stops there.
    assign wr_ok      = active && bus.acc_valid && !abort_hit && (w_q != W_FULL);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = RUN;
            RUN:   if (bus.abort) state_d = IDLE;
                   else if (issue_last) state_d = DRAIN;
            DRAIN: if (bus.abort) state_d = IDLE;
                   else if (w_q == W_FULL) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next issue indices: k innermost, then j, then i.
    always_comb begin
        k_d = k_q + AW'(1);
        j_d = j_q;
        i_d = i_q;
        if (k_q == KMAX) begin
            j_d = j_q + AW'(1);
            if (j_q == KMAX) i_d = i_q + AW'(1);
        end
    end

    // Issue counters, control delay line and result path
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            rd_en_q     <= 1'b0;
            a_addr_q    <= '0;
            b_addr_q    <= '0;
            en_pipe_q   <= '0;
            last_pipe_q <= '0;
            clr_q       <= 1'b0;
            w_q         <= '0;
            c_we_q      <= 1'b0;
            c_addr_q    <= '0;
            c_data_q    <= '0;
        end else begin
            clr_q  <= abort_hit;
            c_we_q <= wr_ok;
            if (abort_hit) begin
                // Flush in-flight operands so the MAC sees nothing further.
                rd_en_q     <= 1'b0;
                en_pipe_q   <= '0;
                last_pipe_q <= '0;
            end else begin
                for (int s = MEM_LAT-1; s > 0; s--) begin
                    en_pipe_q[s]   <= en_pipe_q[s-1];
                    last_pipe_q[s] <= last_pipe_q[s-1];
                end
                en_pipe_q[0]   <= rd_en_q;
                last_pipe_q[0] <= rd_en_q && (k_q == KMAX);

                if (accept) begin
                    i_q      <= '0;
                    j_q      <= '0;
                    k_q      <= '0;
                    rd_en_q  <= 1'b1;
                    a_addr_q <= '0;
                    b_addr_q <= '0;
                end else if (state_q == RUN) begin
                    if (issue_last) begin
                        rd_en_q <= 1'b0;
                    end else begin
                        i_q      <= i_d;
                        j_q      <= j_d;
                        k_q      <= k_d;
                        rd_en_q  <= 1'b1;
                        a_addr_q <= {i_d, k_d};
                        b_addr_q <= {k_d, j_d};
                    end
                end
            end

            if (accept) begin
                w_q <= '0;
            end else if (wr_ok) begin
                // Low 2*AW bits of w are {w_i, w_j}: row-major C address.
                c_addr_q <= w_q[2*AW-1:0];
                c_data_q <= bus.acc_data;
                w_q      <= w_q + WW'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        bus.busy     = active;
        bus.done     = (state_q == DONE);
        // Clear fires in the accepting cycle itself, and the cycle after an abort.
        bus.mac_clr  = clr_q || (accept && !rst);
        bus.rd_en    = rd_en_q;
        bus.a_addr   = a_addr_q;
        bus.b_addr   = b_addr_q;
        bus.mac_en   = en_pipe_q[MEM_LAT-1];
        bus.mac_last = last_pipe_q[MEM_LAT-1];
        bus.c_we     = c_we_q;
        bus.c_addr   = c_addr_q;
        bus.c_data   = c_data_q;
    end

`ifdef MAT_MAC_SEQ_PERF_EN
    logic [6:0] drain_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt     <= '0;
            stall_err   <= 1'b0;
            drain_cnt_q <= '0;
        end else if (accept) begin
            cyc_cnt     <= '0;
            stall_err   <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            if (active && (cyc_cnt != 32'hFFFF_FFFF)) cyc_cnt <= cyc_cnt + 32'd1;
            if (state_q == DRAIN) begin
                // drain_cnt_q == 64 means this is the 65th DRAIN cycle.
                if (drain_cnt_q == 7'd64) stall_err <= 1'b1;
                else drain_cnt_q <= drain_cnt_q + 7'd1;
            end
        end
    end
`endif
endmodule
